// File: rtl/instr_encoder.sv
// instr_encoder: packs instruction class, register, funct and immediate
// fields into RV32 instruction words and queues them in a small output FIFO
// with valid/ready handshakes on both sides. Illegal field combinations are
// stored with an error flag and an all-zero word.
// Optional feature macro: INSTR_ENCODER_ERR_CNT_EN adds the err_count output.
module instr_encoder #(
  parameter int DEPTH     = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_fmt,
  input  logic [4:0]           in_rd,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [2:0]           in_funct3,
  input  logic [6:0]           in_funct7,
  input  logic [31:0]          in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic                 out_err,
`ifdef INSTR_ENCODER_ERR_CNT_EN
  output logic [CNT_WIDTH-1:0] err_count,
`endif
  output logic [CNT_WIDTH-1:0] enc_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_J     = 7'b1101111;
  localparam logic [6:0] OP_FP    = 7'b1010011;

  // Returns {err, word}; an illegal request yields err=1 and a zero word so
  // nothing is ever silently truncated.
  function automatic logic [32:0] encode(
    input logic [3:0]  fmt,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [31:0] imm
  );
    logic [31:0] word;
    logic        bad;
    logic        imm12_ok;
    word     = '0;
    bad      = 1'b0;
    imm12_ok = (imm[31:11] == {21{imm[11]}});
    case (fmt)
      4'd0: word = {f7, rs2, rs1, f3, rd, OP_R};
      4'd1: begin
        word = {imm[11:0], rs1, f3, rd, OP_I};
        bad  = !imm12_ok;
      end
      4'd2: begin
        word = {imm[11:0], rs1, f3, rd, OP_LOAD};
        bad  = !imm12_ok || (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      4'd3: begin
        word = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
        bad  = !imm12_ok;
      end
      4'd4: begin
        word = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_S};
        bad  = !imm12_ok;
      end
      4'd5: begin
        word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_B};
        bad  = (imm[31:12] != {20{imm[12]}}) || imm[0] ||
               (f3 == 3'b010) || (f3 == 3'b011);
      end
      4'd6: begin
        word = {imm[31:12], rd, OP_LUI};
        bad  = (imm[11:0] != 12'd0);
      end
      4'd7: begin
        word = {imm[31:12], rd, OP_AUIPC};
        bad  = (imm[11:0] != 12'd0);
      end
      4'd8: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_J};
        bad  = (imm[31:20] != {12{imm[20]}}) || imm[0];
      end
      4'd9: word = {f7, rs2, rs1, f3, rd, OP_FP};
      default: bad = 1'b1;
    endcase
    return bad ? {1'b1, 32'd0} : {1'b0, word};
  endfunction

  logic              vld_p0;
  logic [31:0]       enc_word_p0;
  logic              enc_err_p0;
  logic [31:0]       fifo_instr_p1 [DEPTH];
  logic              fifo_err_p1   [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W:0]    count;
  logic              rst_done;
  logic              push;
  logic              pop;

  // ---- stage p0: combinational encode of the incoming request ----
  assign vld_p0                    = in_valid;
  assign {enc_err_p0, enc_word_p0} = encode(in_fmt, in_rd, in_rs1, in_rs2,
                                            in_funct3, in_funct7, in_imm);

  assign in_ready  = rst_done && (count < DEPTH_C);
  assign out_valid = (count != '0);
  assign push      = vld_p0 && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_instr = out_valid ? fifo_instr_p1[head] : 32'd0;
  assign out_err   = out_valid ? fifo_err_p1[head]   : 1'b0;

  // Hold in_ready low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_done <= 1'b0;
    else        rst_done <= 1'b1;
  end

  // ---- stage p1: FIFO storage, written at the tail on push ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_instr_p1[i] <= 32'd0;
        fifo_err_p1[i]   <= 1'b0;
      end
    end else if (push) begin
      fifo_instr_p1[tail] <= enc_word_p0;
      fifo_err_p1[tail]   <= enc_err_p0;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Count accepted legal requests; wraps modulo 2^CNT_WIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    enc_count <= '0;
    else if (push && !enc_err_p0)  enc_count <= enc_count + 1'b1;
  end

`ifdef INSTR_ENCODER_ERR_CNT_EN
  // Count accepted illegal requests; wraps modulo 2^CNT_WIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   err_count <= '0;
    else if (push && enc_err_p0)  err_count <= err_count + 1'b1;
  end
`endif

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Encoder counterpart to the core's instruction decoder/control unit: takes instruction class plus register, funct and immediate fields, and emits the 32-bit RV32 instruction word.
- Used by the boot/test program builder and by the self-check harness to generate instruction streams that feed instruction memory.
- Accepted requests are stored in a small output FIFO with valid/ready handshakes on both sides.
- Illegal field combinations are flagged with an error bit per entry, never silently truncated.

Parameters:
DEPTH, 2, output FIFO entries (power of two, >=2)
CNT_WIDTH, 16, width of the statistics counters

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  request accepted when in_valid&&in_ready at a rising clk edge
in_fmt  input  4  0 R, 1 I-alu, 2 LOAD, 3 JALR, 4 S, 5 B, 6 LUI, 7 AUIPC, 8 J, 9 FP; 10-15 illegal
in_rd  input  5  destination register
in_rs1  input  5  source register 1
in_rs2  input  5  source register 2
in_funct3  input  3  funct3 field
in_funct7  input  7  funct7 field (R/FP only)
in_imm  input  32  sign-extended byte-offset/immediate
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer ready; pop on out_valid&&out_ready
out_instr  output  32  encoded word at FIFO head
out_err  output  1  head entry illegal (out_instr is 0 for such entries)
enc_count  output  CNT_WIDTH  count of accepted legal requests, wraps modulo 2^CNT_WIDTH

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Encoding is combinational from the in_* fields and is captured into the FIFO tail on push.
- Opcodes:
  - R 0110011, I 0010011, LOAD 0000011, JALR 1100111, S 0100011
  - B 1100011, LUI 0110111, AUIPC 0010111, J 1101111, FP 1010011
- Field packing, R/FP: funct7|rs2|rs1|f3|rd|op.
- Field packing, I/LOAD/JALR: imm[11:0]|rs1|f3|rd|op. JALR forces f3=000.
- Field packing, S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op.
- Field packing, B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op.
- Field packing, LUI/AUIPC: imm[31:12]|rd|op.
- Field packing, J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
- Error conditions (entry stored with err=1 and instr=0):
  - I/LOAD/JALR/S: imm[31:11] not all equal.
  - B: imm[31:12] not all equal, or imm[0]=1, or f3 is 010 or 011.
  - J: imm[31:20] not all equal, or imm[0]=1.
  - LUI/AUIPC: imm[11:0] != 0.
  - LOAD: f3 is 011, 110 or 111.
  - fmt 10-15.
- FIFO structure: head/tail pointers of log2(DEPTH) bits plus an occupancy count of log2(DEPTH)+1 bits.
- Handshake rules:
  - in_ready = (count < DEPTH). It is registered-state only and has no combinational path from out_ready.
  - out_valid = (count != 0). out_instr and out_err are driven from the head entry.
  - out_instr and out_err are held stable while out_valid && !out_ready.
- Latency: a request pushed at edge k appears at out_valid/out_instr after edge k when the FIFO was empty (1 cycle).
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
- Full FIFO: in_ready=0, so only a pop can occur.
- Pointers wrap modulo DEPTH. Output order equals acceptance order.
- enc_count increments on each push with err=0 and wraps at the maximum value.
- Reset (asynchronous, including mid-operation), effective immediately on rst_n low:
  - count=0, pointers=0, all storage=0.
  - Outputs: out_valid=0, out_instr=0, out_err=0, in_ready=0 while rst_n is low, enc_count=0.
  - Pending entries are discarded.
  - in_ready=1 on the first edge after rst_n deasserts.

Optional Feature:
- Macro: INSTR_ENCODER_ERR_CNT_EN.
- When defined: adds output err_count (CNT_WIDTH). It increments on each push with err=1, wraps at the maximum value, and resets to 0.
- When undefined: the port and its counter are absent. Error entries are still flagged through out_err.

Test Plan:
- add x3,x1,x2 (fmt0, rd3, rs1 1, rs2 2, f3 0, f7 0), out_ready=1 -> next cycle out_valid=1, out_instr=0x002081B3, out_err=0, enc_count=1.
- addi x1,x0,-1 (fmt1, rd1, imm 0xFFFFFFFF) -> 0xFFF00093. Same request with imm 0x00000800 -> out_err=1, out_instr=0, enc_count unchanged.
- beq x1,x2,+8 (fmt5, f3 0, rs1 1, rs2 2, imm 8) -> 0x00208463. Same request with imm 7 -> out_err=1.
- lui x5,0x12345 (fmt6, rd5, imm 0x12345000) -> 0x123452B7. Same request with imm 0x12345001 -> out_err=1 (err_count=1 when the macro is defined).
- Backpressure with DEPTH=2, out_ready=0, three back-to-back requests:
  - in_ready=0 after two accepts; the third request is held and out_instr stays stable.
  - Raise out_ready -> three words appear in order.
  - Simultaneous push/pop at count=1 keeps count=1.
- Reset mid-operation: count=2, assert rst_n low between edges -> out_valid=0, out_instr=0, enc_count=0 immediately. After release, a new request emerges with no stale entries.
